// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - widths, ALU opcodes and EX-slot record shared by id_ex_stage (ID_EX_FORWARD_EN aware users)
package id_ex_stage_pkg;

  localparam int WORD      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ALU_OP_W  = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_EQ    = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_LE    = 4'hA;
  localparam logic [ALU_OP_W-1:0] ALU_NO_OP = 4'hF;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rs_idx;
    logic [REG_IDX_W-1:0] rt_idx;
    logic [REG_IDX_W-1:0] rd;
    logic [WORD-1:0]      rs_val;
    logic [WORD-1:0]      rt_val;
    logic [WORD-1:0]      imm;
    logic [REG_IDX_W-1:0] shamt;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 use_imm;
    logic                 use_shamt;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
  } ex_slot_t;

  // Empty EX slot: nothing live, nothing written, ALU idle.
  function automatic ex_slot_t ex_bubble();
    ex_slot_t b;
    b        = '0;
    b.alu_op = ALU_NO_OP;
    return b;
  endfunction

  // A producer with write enable and matching destination; register 0 never matches.
  function automatic logic src_hit(input logic we, input logic [REG_IDX_W-1:0] rd,
                                   input logic [REG_IDX_W-1:0] idx);
    return we && (rd == idx) && (idx != '0);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// rtl/id_ex_stage_fwd_sel.sv - one operand bypass mux, EX/MEM result preferred over WB data
module id_ex_stage_fwd_sel
  import id_ex_stage_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_idx,
  input  logic [WORD-1:0]      reg_val,
  input  logic                 exm_reg_write,
  input  logic [REG_IDX_W-1:0] exm_rd,
  input  logic [WORD-1:0]      exm_result,
  input  logic                 wb_reg_write,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [WORD-1:0]      wb_data,
  output logic [WORD-1:0]      fwd_val
);

  // Youngest producer wins; otherwise the value latched at decode.
  always_comb begin
    fwd_val = reg_val;
    if (src_hit(exm_reg_write, exm_rd, src_idx)) begin
      fwd_val = exm_result;
    end else if (src_hit(wb_reg_write, wb_rd, src_idx)) begin
      fwd_val = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX register with hazard handling; ID_EX_FORWARD_EN selects bypass vs stall-only
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs_idx_i,
  input  logic [REG_IDX_W-1:0] id_rt_idx_i,
  input  logic [REG_IDX_W-1:0] id_rd_idx_i,
  input  logic [WORD-1:0]      id_rs_val_i,
  input  logic [WORD-1:0]      id_rt_val_i,
  input  logic [WORD-1:0]      id_imm_i,
  input  logic [REG_IDX_W-1:0] id_shamt_i,
  input  logic [ALU_OP_W-1:0]  id_alu_op_i,
  input  logic                 id_use_imm_i,
  input  logic                 id_use_shamt_i,
  input  logic                 id_reg_write_i,
  input  logic                 id_mem_read_i,
  input  logic                 id_mem_write_i,
  input  logic                 exm_reg_write_i,
  input  logic [REG_IDX_W-1:0] exm_rd_i,
  input  logic [WORD-1:0]      exm_result_i,
  input  logic                 wb_reg_write_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [WORD-1:0]      wb_data_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 id_stall_o,
  output logic                 ex_valid_o,
  output logic [WORD-1:0]      ex_data1_o,
  output logic [WORD-1:0]      ex_data2_o,
  output logic [ALU_OP_W-1:0]  ex_alu_op_o,
  output logic [WORD-1:0]      ex_store_data_o,
  output logic [REG_IDX_W-1:0] ex_rd_o,
  output logic                 ex_reg_write_o,
  output logic                 ex_mem_read_o,
  output logic                 ex_mem_write_o
);

  ex_slot_t        ex_q;
  ex_slot_t        id_d;
  logic [WORD-1:0] rs_cap, rt_cap;
  logic [WORD-1:0] rs_fwd, rt_fwd;
  logic            rs_used, rt_used;
  logic            hazard;

  // Which source fields the decoded instruction actually reads.
  always_comb begin
    rs_used = !id_use_shamt_i;
    rt_used = !id_use_imm_i || id_mem_write_i;
  end

`ifdef ID_EX_FORWARD_EN
  // Only a load still in EX cannot be bypassed; everything else is forwarded.
  always_comb begin
    hazard = 1'b0;
    if (id_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)) begin
      hazard = (rs_used && (ex_q.rd == id_rs_idx_i)) ||
               (rt_used && (ex_q.rd == id_rt_idx_i));
    end
  end

  // WB retires this cycle and the regfile does not write through, so grab it at decode.
  always_comb begin
    rs_cap = src_hit(wb_reg_write_i, wb_rd_i, id_rs_idx_i) ? wb_data_i : id_rs_val_i;
    rt_cap = src_hit(wb_reg_write_i, wb_rd_i, id_rt_idx_i) ? wb_data_i : id_rt_val_i;
  end

  id_ex_stage_fwd_sel u_rs_fwd (
    .src_idx(ex_q.rs_idx), .reg_val(ex_q.rs_val),
    .exm_reg_write(exm_reg_write_i), .exm_rd(exm_rd_i), .exm_result(exm_result_i),
    .wb_reg_write(wb_reg_write_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
    .fwd_val(rs_fwd)
  );

  id_ex_stage_fwd_sel u_rt_fwd (
    .src_idx(ex_q.rt_idx), .reg_val(ex_q.rt_val),
    .exm_reg_write(exm_reg_write_i), .exm_rd(exm_rd_i), .exm_result(exm_result_i),
    .wb_reg_write(wb_reg_write_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
    .fwd_val(rt_fwd)
  );
`else
  logic unused_bypass;

  // Without bypass, any in-flight writer of a used source holds decode until it retires.
  always_comb begin
    hazard = 1'b0;
    if (id_valid_i) begin
      hazard = (rs_used && (src_hit(ex_q.valid && ex_q.reg_write, ex_q.rd, id_rs_idx_i) ||
                            src_hit(exm_reg_write_i, exm_rd_i, id_rs_idx_i) ||
                            src_hit(wb_reg_write_i, wb_rd_i, id_rs_idx_i))) ||
               (rt_used && (src_hit(ex_q.valid && ex_q.reg_write, ex_q.rd, id_rt_idx_i) ||
                            src_hit(exm_reg_write_i, exm_rd_i, id_rt_idx_i) ||
                            src_hit(wb_reg_write_i, wb_rd_i, id_rt_idx_i)));
    end
  end

  // Operands come straight from the regfile read and the latched EX slot.
  always_comb begin
    rs_cap = id_rs_val_i;
    rt_cap = id_rt_val_i;
    rs_fwd = ex_q.rs_val;
    rt_fwd = ex_q.rt_val;
  end

  assign unused_bypass = ^{exm_result_i, wb_data_i, ex_q.rs_idx, ex_q.rt_idx};
`endif

  assign id_stall_o = hazard && !flush_i;

  // Next EX slot from decode; an empty decode slot becomes a bubble.
  always_comb begin
    id_d = ex_bubble();
    if (id_valid_i) begin
      id_d.valid     = 1'b1;
      id_d.rs_idx    = id_rs_idx_i;
      id_d.rt_idx    = id_rt_idx_i;
      id_d.rd        = id_rd_idx_i;
      id_d.rs_val    = rs_cap;
      id_d.rt_val    = rt_cap;
      id_d.imm       = id_imm_i;
      id_d.shamt     = id_shamt_i;
      id_d.alu_op    = id_alu_op_i;
      id_d.use_imm   = id_use_imm_i;
      id_d.use_shamt = id_use_shamt_i;
      id_d.reg_write = id_reg_write_i;
      id_d.mem_read  = id_mem_read_i;
      id_d.mem_write = id_mem_write_i;
    end
  end

  // EX slot: reset, then flush, then external hold (keeps a blocking load in place), then hazard bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= ex_bubble();
    end else if (flush_i) begin
      ex_q <= ex_bubble();
    end else if (stall_i) begin
      ex_q <= ex_q;
    end else if (id_stall_o) begin
      ex_q <= ex_bubble();
    end else begin
      ex_q <= id_d;
    end
  end

  // ALU operand selection on the EX side.
  always_comb begin
    ex_data1_o      = ex_q.use_shamt ? {{(WORD-REG_IDX_W){1'b0}}, ex_q.shamt} : rs_fwd;
    ex_data2_o      = ex_q.use_imm ? ex_q.imm : rt_fwd;
    ex_store_data_o = rt_fwd;
    ex_valid_o      = ex_q.valid;
    ex_alu_op_o     = ex_q.alu_op;
    ex_rd_o         = ex_q.rd;
    ex_reg_write_o  = ex_q.reg_write;
    ex_mem_read_o   = ex_q.mem_read;
    ex_mem_write_o  = ex_q.mem_write;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage, both ID_EX_FORWARD_EN builds
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_rs_idx_i, id_rt_idx_i, id_rd_idx_i, id_shamt_i;
  logic [31:0] id_rs_val_i, id_rt_val_i, id_imm_i;
  logic [3:0]  id_alu_op_i;
  logic        id_use_imm_i, id_use_shamt_i, id_reg_write_i, id_mem_read_i, id_mem_write_i;
  logic        exm_reg_write_i, wb_reg_write_i;
  logic [4:0]  exm_rd_i, wb_rd_i;
  logic [31:0] exm_result_i, wb_data_i;
  logic        stall_i, flush_i;
  logic        id_stall_o, ex_valid_o;
  logic [31:0] ex_data1_o, ex_data2_o, ex_store_data_o;
  logic [3:0]  ex_alu_op_o;
  logic [4:0]  ex_rd_o;
  logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_NOP = 4'hF;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
    .id_rs_idx_i(id_rs_idx_i), .id_rt_idx_i(id_rt_idx_i), .id_rd_idx_i(id_rd_idx_i),
    .id_rs_val_i(id_rs_val_i), .id_rt_val_i(id_rt_val_i), .id_imm_i(id_imm_i),
    .id_shamt_i(id_shamt_i), .id_alu_op_i(id_alu_op_i), .id_use_imm_i(id_use_imm_i),
    .id_use_shamt_i(id_use_shamt_i), .id_reg_write_i(id_reg_write_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .exm_reg_write_i(exm_reg_write_i), .exm_rd_i(exm_rd_i), .exm_result_i(exm_result_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .stall_i(stall_i), .flush_i(flush_i), .id_stall_o(id_stall_o), .ex_valid_o(ex_valid_o),
    .ex_data1_o(ex_data1_o), .ex_data2_o(ex_data2_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid_i = 0; id_rs_idx_i = 0; id_rt_idx_i = 0; id_rd_idx_i = 0;
    id_rs_val_i = 0; id_rt_val_i = 0; id_imm_i = 0; id_shamt_i = 0; id_alu_op_i = OP_ADD;
    id_use_imm_i = 0; id_use_shamt_i = 0; id_reg_write_i = 0; id_mem_read_i = 0; id_mem_write_i = 0;
    exm_reg_write_i = 0; exm_rd_i = 0; exm_result_i = 0;
    wb_reg_write_i = 0; wb_rd_i = 0; wb_data_i = 0; stall_i = 0; flush_i = 0;
  endtask

  task automatic idle();
    clear_inputs();
    tick();
  endtask

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm,
                          input logic [4:0] sh, input logic [3:0] op, input logic ui,
                          input logic us, input logic rw, input logic mr, input logic mw);
    id_valid_i = 1; id_rs_idx_i = rs; id_rt_idx_i = rt; id_rd_idx_i = rd;
    id_rs_val_i = rsv; id_rt_val_i = rtv; id_imm_i = imm; id_shamt_i = sh; id_alu_op_i = op;
    id_use_imm_i = ui; id_use_shamt_i = us; id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw;
  endtask

  task automatic test_reset();
    clear_inputs();
    drive_id(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    tick();
    vectors++; if (ex_valid_o !== 1'b1 || ex_data1_o !== 32'h5) begin miscompares++; $display("FAIL reset_preload: valid=%b data1=%h, want 1 00000005", ex_valid_o, ex_data1_o); end
    rst = 1; stall_i = 1;
    tick();
    vectors++; if (ex_valid_o !== 1'b0 || ex_alu_op_o !== OP_NOP) begin miscompares++; $display("FAIL reset_valid_op: valid=%b op=%h, want 0 f", ex_valid_o, ex_alu_op_o); end
    vectors++; if ({ex_data1_o, ex_data2_o, ex_store_data_o} !== 96'h0 || ex_rd_o !== 5'd0) begin miscompares++; $display("FAIL reset_data: d1=%h d2=%h st=%h rd=%0d, want all 0", ex_data1_o, ex_data2_o, ex_store_data_o, ex_rd_o); end
    vectors++; if ({ex_reg_write_o, ex_mem_read_o, ex_mem_write_o} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl: ctrl=%b, want 000", {ex_reg_write_o, ex_mem_read_o, ex_mem_write_o}); end
    rst = 0;
    idle();
  endtask

  task automatic test_hold();
    idle();
    drive_id(5'd11, 5'd12, 5'd10, 32'h11, 32'h22, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    tick();
    drive_id(5'd14, 5'd15, 5'd13, 32'h33, 32'h44, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    stall_i = 1;
    tick();
    vectors++; if (ex_data1_o !== 32'h11 || ex_rd_o !== 5'd10) begin miscompares++; $display("FAIL hold_keeps: d1=%h rd=%0d, want 00000011 10", ex_data1_o, ex_rd_o); end
    stall_i = 0;
    tick();
    vectors++; if (ex_data1_o !== 32'h33 || ex_data2_o !== 32'h44 || ex_rd_o !== 5'd13) begin miscompares++; $display("FAIL hold_release: d1=%h d2=%h rd=%0d, want 00000033 00000044 13", ex_data1_o, ex_data2_o, ex_rd_o); end
  endtask

  task automatic test_src_usage();
    idle();
    drive_id(5'd1, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4, 5'd0, OP_ADD, 1, 0, 1, 1, 0);
    tick();
    drive_id(5'd1, 5'd3, 5'd4, 32'h1, 32'h99, 32'h8, 5'd0, OP_ADD, 1, 0, 1, 0, 0);
    #1;
    vectors++; if (id_stall_o !== 1'b0) begin miscompares++; $display("FAIL imm_ignores_rt: stall=%b, want 0", id_stall_o); end
    id_reg_write_i = 0; id_mem_write_i = 1;
    #1;
    vectors++; if (id_stall_o !== 1'b1) begin miscompares++; $display("FAIL store_uses_rt: stall=%b, want 1", id_stall_o); end
    drive_id(5'd3, 5'd0, 5'd4, 32'h99, 32'h0, 32'h0, 5'd2, OP_SLL, 0, 1, 1, 0, 0);
    #1;
    vectors++; if (id_stall_o !== 1'b0) begin miscompares++; $display("FAIL shamt_ignores_rs: stall=%b, want 0", id_stall_o); end
    drive_id(5'd3, 5'd3, 5'd4, 32'h99, 32'h99, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    id_valid_i = 0;
    #1;
    vectors++; if (id_stall_o !== 1'b0) begin miscompares++; $display("FAIL invalid_no_stall: stall=%b, want 0", id_stall_o); end
    idle();
  endtask

  task automatic test_flush_shamt();
    idle();
    drive_id(5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'h4, 5'd0, OP_ADD, 1, 0, 1, 1, 0);
    tick();
    drive_id(5'd6, 5'd2, 5'd8, 32'h99, 32'h3, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    flush_i = 1;
    #1;
    vectors++; if (id_stall_o !== 1'b0) begin miscompares++; $display("FAIL flush_gates_stall: stall=%b, want 0", id_stall_o); end
    tick();
    vectors++; if ({ex_valid_o, ex_reg_write_o, ex_mem_read_o} !== 3'b000 || ex_alu_op_o !== OP_NOP) begin miscompares++; $display("FAIL flush_bubble: v/rw/mr=%b op=%h, want 000 f", {ex_valid_o, ex_reg_write_o, ex_mem_read_o}, ex_alu_op_o); end
    flush_i = 0;
    drive_id(5'd0, 5'd2, 5'd9, 32'h0, 32'h9, 32'h0, 5'd4, OP_SLL, 0, 1, 1, 0, 0);
    tick();
    vectors++; if (ex_data1_o !== 32'h4 || ex_data2_o !== 32'h9 || ex_alu_op_o !== OP_SLL) begin miscompares++; $display("FAIL sll_shamt: d1=%h d2=%h op=%h, want 00000004 00000009 5", ex_data1_o, ex_data2_o, ex_alu_op_o); end
    idle();
  endtask

`ifdef ID_EX_FORWARD_EN
  task automatic test_back_to_back();
    idle();
    drive_id(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    tick();
    drive_id(5'd3, 5'd3, 5'd4, 32'h99, 32'h99, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    #1;
    vectors++; if (id_stall_o !== 1'b0) begin miscompares++; $display("FAIL raw_alu_no_stall: stall=%b, want 0", id_stall_o); end
    tick();
    clear_inputs();
    exm_reg_write_i = 1; exm_rd_i = 5'd3; exm_result_i = 32'h10;
    #1;
    vectors++; if (ex_data1_o !== 32'h10 || ex_data2_o !== 32'h10 || ex_store_data_o !== 32'h10) begin miscompares++; $display("FAIL exm_forward: d1=%h d2=%h st=%h, want 00000010 x3", ex_data1_o, ex_data2_o, ex_store_data_o); end
    idle();
  endtask

  task automatic test_priority();
    idle();
    drive_id(5'd5, 5'd0, 5'd7, 32'h1, 32'h2, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    tick();
    clear_inputs();
    exm_reg_write_i = 1; exm_rd_i = 5'd5; exm_result_i = 32'hAA;
    wb_reg_write_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'hBB;
    #1;
    vectors++; if (ex_data1_o !== 32'hAA) begin miscompares++; $display("FAIL exm_beats_wb: d1=%h, want 000000aa", ex_data1_o); end
    exm_rd_i = 5'd0; exm_result_i = 32'hCC; wb_rd_i = 5'd0; wb_data_i = 32'hDD;
    #1;
    vectors++; if (ex_data2_o !== 32'h2 || ex_data1_o !== 32'h1) begin miscompares++; $display("FAIL reg0_not_fwd: d1=%h d2=%h, want 00000001 00000002", ex_data1_o, ex_data2_o); end
    exm_reg_write_i = 0; wb_rd_i = 5'd5;
    #1;
    vectors++; if (ex_data1_o !== 32'hDD) begin miscompares++; $display("FAIL wb_forward: d1=%h, want 000000dd", ex_data1_o); end
    idle();
  endtask

  task automatic test_load_use();
    int stalls;
    idle();
    drive_id(5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 32'h4, 5'd0, OP_ADD, 1, 0, 1, 1, 0);
    tick();
    drive_id(5'd6, 5'd2, 5'd8, 32'h99, 32'h3, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      exm_reg_write_i = (k == 1); exm_rd_i = (k == 1) ? 5'd6 : 5'd0; exm_result_i = 32'h104;
      #1;
      if (!id_stall_o) break;
      stalls++;
      tick();
      if (k == 0) begin
        vectors++; if (ex_valid_o !== 1'b0 || ex_reg_write_o !== 1'b0) begin miscompares++; $display("FAIL load_use_bubble: valid=%b rw=%b, want 0 0", ex_valid_o, ex_reg_write_o); end
      end
    end
    vectors++; if (stalls != 1) begin miscompares++; $display("FAIL load_use_stalls: %0d cycles, want 1", stalls); end
    tick();
    clear_inputs();
    wb_reg_write_i = 1; wb_rd_i = 5'd6; wb_data_i = 32'h55;
    #1;
    vectors++; if (ex_data1_o !== 32'h55 || ex_data2_o !== 32'h3 || ex_rd_o !== 5'd8) begin miscompares++; $display("FAIL load_use_wb_fwd: d1=%h d2=%h rd=%0d, want 00000055 00000003 8", ex_data1_o, ex_data2_o, ex_rd_o); end
    idle();
  endtask

  task automatic test_decode_capture();
    idle();
    drive_id(5'd9, 5'd0, 5'd10, 32'h99, 32'h0, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    wb_reg_write_i = 1; wb_rd_i = 5'd9; wb_data_i = 32'h77;
    tick();
    clear_inputs();
    #1;
    vectors++; if (ex_data1_o !== 32'h77) begin miscompares++; $display("FAIL decode_capture: d1=%h, want 00000077", ex_data1_o); end
    idle();
  endtask
`else
  task automatic test_no_bypass();
    int stalls;
    idle();
    drive_id(5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    tick();
    vectors++; if (ex_data1_o !== 32'h5 || ex_data2_o !== 32'h7 || ex_rd_o !== 5'd3) begin miscompares++; $display("FAIL producer_ex: d1=%h d2=%h rd=%0d, want 00000005 00000007 3", ex_data1_o, ex_data2_o, ex_rd_o); end
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      drive_id(5'd3, 5'd3, 5'd4, (k >= 3) ? 32'h10 : 32'h99, (k >= 3) ? 32'h10 : 32'h99,
               32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
      exm_reg_write_i = (k == 1); exm_rd_i = (k == 1) ? 5'd3 : 5'd0; exm_result_i = 32'h10;
      wb_reg_write_i = (k == 2); wb_rd_i = (k == 2) ? 5'd3 : 5'd0; wb_data_i = 32'h10;
      #1;
      if (k > 0) begin
        vectors++; if (ex_valid_o !== 1'b0 || ex_data1_o !== 32'h0) begin miscompares++; $display("FAIL stall_bubble_no_bypass: valid=%b d1=%h, want 0 00000000", ex_valid_o, ex_data1_o); end
      end
      if (!id_stall_o) break;
      stalls++;
      tick();
    end
    vectors++; if (stalls != 3) begin miscompares++; $display("FAIL raw_stall_cycles: %0d, want 3", stalls); end
    tick();
    vectors++; if (ex_data1_o !== 32'h10 || ex_data2_o !== 32'h10 || ex_rd_o !== 5'd4) begin miscompares++; $display("FAIL raw_operands: d1=%h d2=%h rd=%0d, want 00000010 00000010 4", ex_data1_o, ex_data2_o, ex_rd_o); end
    idle();
  endtask

  task automatic test_reg0();
    idle();
    drive_id(5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    tick();
    drive_id(5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 5'd0, OP_ADD, 0, 0, 1, 0, 0);
    exm_reg_write_i = 1; exm_rd_i = 5'd0; wb_reg_write_i = 1; wb_rd_i = 5'd0;
    #1;
    vectors++; if (id_stall_o !== 1'b0) begin miscompares++; $display("FAIL reg0_no_stall: stall=%b, want 0", id_stall_o); end
    idle();
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_hold();
    test_src_usage();
    test_flush_shamt();
`ifdef ID_EX_FORWARD_EN
    test_back_to_back();
    test_priority();
    test_load_use();
    test_decode_capture();
`else
    test_no_bypass();
    test_reg0();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
